// File: rtl/myprotocol_pkg.sv
// Shared types and defaults for the sig1/sig2 toggle-protocol monitor.
package myprotocol_pkg;

    typedef enum logic [1:0] {IDLE, BURST, DONE} mon_state_t;

    localparam int EXP_TOGGLES_DEF = 10;
    localparam int GAP_CYCLES_DEF  = 4;
    localparam int CNT_W_DEF       = 8;
    localparam int NUM_LINES       = 2;

    localparam logic SIG1_IDLE = 1'b0;
    localparam logic SIG2_IDLE = 1'b1;

endpackage

// File: rtl/myprotocol_edge_det.sv
// Per-line front end: optional 2-flop synchronizer, previous-sample reg, toggle detect.
// Define MYPROTO_MON_SYNC_EN to insert the synchronizer (adds 2 cycles of latency).
module myprotocol_edge_det #(
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic toggle
);
    logic line;
    logic line_q;

`ifdef MYPROTO_MON_SYNC_EN
    logic [1:0] sync;

    // Reset to the idle level so leaving reset never looks like a transition.
    always_ff @(posedge clk) begin
        if (rst) sync <= {2{IDLE_LVL}};
        else     sync <= {sync[0], sig};
    end

    assign line = sync[1];
`else
    assign line = sig;
`endif

    always_ff @(posedge clk) begin
        if (rst) line_q <= IDLE_LVL;
        else     line_q <= line;
    end

    assign toggle = line ^ line_q;

endmodule

// File: rtl/myprotocol_monitor.sv
// Receive-side checker for the sig1/sig2 toggle protocol: counts toggles per burst, reports pass/fail.
// Define MYPROTO_MON_SYNC_EN to synchronize asynchronous lines before toggle detect.
module myprotocol_monitor
    import myprotocol_pkg::*;
#(
    parameter int EXP_TOGGLES = EXP_TOGGLES_DEF,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig1,
    input  logic             sig2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    // An expected count beyond the counter range can never be matched.
    localparam bit               EXP_OK   = (longint'(EXP_TOGGLES) >= 0) &&
                                            (longint'(EXP_TOGGLES) <= longint'(CNT_MAX));
    localparam logic [CNT_W-1:0] EXP_C    = CNT_W'(EXP_TOGGLES);
    localparam logic [NUM_LINES-1:0] IDLE_LVLS = {SIG2_IDLE, SIG1_IDLE};

    mon_state_t                       state;
    logic [NUM_LINES-1:0]             lines;
    logic [NUM_LINES-1:0]             tog;
    logic                             any_tog;
    logic [NUM_LINES-1:0][CNT_W-1:0]  cnt_int;
    logic [NUM_LINES-1:0][CNT_W-1:0]  cnt_inc;
    logic [GAP_W-1:0]                 gap;
    logic                             line_pass;

    assign lines   = {sig2, sig1};
    assign any_tog = |tog;

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        myprotocol_edge_det #(
            .IDLE_LVL (IDLE_LVLS[i])
        ) u_edge (
            .clk    (clk),
            .rst    (rst),
            .sig    (lines[i]),
            .toggle (tog[i])
        );
    end

    // Saturating per-line increment; counts are zero in IDLE/DONE so this also seeds a new burst.
    always_comb begin
        cnt_inc = cnt_int;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (tog[i] && (cnt_int[i] != CNT_MAX)) cnt_inc[i] = cnt_int[i] + CNT_W'(1);
        end
    end

    always_comb begin
        line_pass = EXP_OK;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (cnt_int[i] != EXP_C) line_pass = 1'b0;
        end
    end

    // Results are loaded on the edge entering DONE so they are visible during the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            cnt1    <= '0;
            cnt2    <= '0;
            err_cnt <= '0;
            cnt_int <= '0;
            gap     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_tog) begin
                        state   <= BURST;
                        busy    <= 1'b1;
                        cnt_int <= cnt_inc;
                        gap     <= '0;
                    end
                end
                BURST: begin
                    if (any_tog) begin
                        cnt_int <= cnt_inc;
                        gap     <= '0;
                    end else if (gap == GAP_LAST) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= line_pass;
                        cnt1    <= cnt_int[0];
                        cnt2    <= cnt_int[1];
                        if (!line_pass && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + CNT_W'(1);
                        cnt_int <= '0;
                        gap     <= '0;
                    end else begin
                        gap <= gap + GAP_W'(1);
                    end
                end
                DONE: begin
                    if (any_tog) begin
                        state   <= BURST;
                        busy    <= 1'b1;
                        cnt_int <= cnt_inc;
                        gap     <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_myprotocol_monitor.sv
// Scoreboard bench for myprotocol_monitor: random bursts, expected results queued per burst.
module tb_myprotocol_monitor;
    localparam int EXP  = 10;
    localparam int GAP  = 4;
    localparam int CW   = 8;
    localparam int CMAX = 255;
`ifdef MYPROTO_MON_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int LAT = GAP + 1 + SYNC_LAT;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          sig1 = 1'b0;
    logic          sig2 = 1'b1;
    logic          busy, done, pass;
    logic [CW-1:0] cnt1, cnt2, err_cnt;

    myprotocol_monitor #(
        .EXP_TOGGLES (EXP),
        .GAP_CYCLES  (GAP),
        .CNT_W       (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sig1    (sig1),
        .sig2    (sig2),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .cnt1    (cnt1),
        .cnt2    (cnt2),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     c1;
        int     c2;
        bit     pass;
        int     err;
        longint cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks    = 0;
    int   failures  = 0;
    int   err_model = 0;
    int   n_exp     = 0;
    int   n_done    = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: a burst reports its saturated per-line counts; it passes only if both equal EXP.
    function automatic void push_exp(input int n1, input int n2, input longint last);
        exp_t e;
        e.c1   = (n1 > CMAX) ? CMAX : n1;
        e.c2   = (n2 > CMAX) ? CMAX : n2;
        e.pass = (e.c1 == EXP) && (e.c2 == EXP);
        if (!e.pass && err_model < CMAX) err_model++;
        e.err  = err_model;
        e.cyc  = last + LAT;
        exp_q.push_back(e);
        n_exp++;
    endfunction

    // sig1 launched just after posedge, sig2 on the following negedge (half-cycle offset).
    task automatic run_burst(input int n1, input int n2, input int pause_at, input int pause_len,
                             output longint last);
        int n;
        n = (n1 > n2) ? n1 : n2;
        last = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (k < n1) sig1 = ~sig1;
            last = cyc;
            if (k == 2) chk("busy_mid_burst", busy, 1);
            @(negedge clk);
            if (k < n2) sig2 = ~sig2;
            if (k == pause_at) repeat (pause_len) @(posedge clk);
            else if (k < n - 1) repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    task automatic quiet();
        repeat (LAT + 6) @(posedge clk);
        #1;
        chk("busy_idle", busy, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("cnt1", cnt1, mon_e.c1);
                chk("cnt2", cnt2, mon_e.c2);
                chk("pass", pass, mon_e.pass);
                chk("err_cnt", err_cnt, mon_e.err);
                chk("done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        longint last;
        longint last2;
        int     r1, r2;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_cnt2", cnt2, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;

        run_burst(10, 10, -1, 0, last);
        push_exp(10, 10, last);
        quiet();

        run_burst(9, 10, -1, 0, last);
        push_exp(9, 10, last);
        quiet();

        // 3 quiet cycles after toggle 5 must not split the burst
        run_burst(10, 10, 4, 3, last);
        push_exp(10, 10, last);
        quiet();

        // toggle landing in the DONE cycle opens a new burst counting that toggle
        run_burst(10, 10, -1, 0, last);
        push_exp(10, 10, last);
        repeat (LAT) @(posedge clk);
        #1;
        chk("done_pulse_at_latency", done, 1);
        sig1 = ~sig1;
        last2 = cyc;
        push_exp(1, 0, last2);
        quiet();

        for (int r = 0; r < 8; r++) begin
            r1 = ($urandom_range(0, 1) == 1) ? EXP : $urandom_range(1, 14);
            r2 = ($urandom_range(0, 1) == 1) ? EXP : $urandom_range(1, 14);
            run_burst(r1, r2, -1, 0, last);
            push_exp(r1, r2, last);
            quiet();
        end

        run_burst(300, 300, -1, 0, last);
        push_exp(300, 300, last);
        quiet();

        // reset mid-burst: no result, held outputs cleared
        run_burst(5, 5, -1, 0, last);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        sig1 = 1'b0;
        sig2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        err_model = 0;
        chk("midrst_cnt1", cnt1, 0);
        chk("midrst_cnt2", cnt2, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        chk("midrst_busy", busy, 0);
        quiet();

        run_burst(10, 10, -1, 0, last);
        push_exp(10, 10, last);
        quiet();

        chk("pending_results", exp_q.size(), 0);
        chk("done_count", n_done, n_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
